uart_word_tx: RTL and testbench
===============================

Name: uart_word_tx

Overview:
UART transmit path for 32-bit words, the counterpart of the word-assembling receiver in top_test. Words are pushed into a small internal FIFO. Each word is serialised as DATA_WIDTH/BYTE_WIDTH UART frames, least-significant byte first, on sig_out. Frame format is 8N1: 1 start bit (0), BYTE_WIDTH data bits LSB first, 1 stop bit (1).

Parameters:
DATA_WIDTH, 32, word width; must be a multiple of BYTE_WIDTH
BYTE_WIDTH, 8, data bits per UART frame
FIFO_DEPTH, 4, word FIFO entries; power of two, >= 2
CLK_FREQ, 200_000_000, clock frequency in Hz
BAUD_RATE, 115200, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer-truncated (1736 at defaults)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; 0 = reset
wr_en  in  1  push request for wr_data
wr_data  in  DATA_WIDTH  word to transmit
full  out  1  FIFO holds FIFO_DEPTH words
empty  out  1  FIFO holds 0 words
busy  out  1  serialiser not in IDLE
word_done  out  1  one-cycle pulse after the final stop bit of a word
sig_out  out  1  UART TX line; idle high

Behaviour:
- Reset (reset=0) takes effect immediately, with no clock edge needed:
  - sig_out=1, full=0, empty=1, busy=0, word_done=0.
  - FIFO pointers cleared; FSM goes to IDLE.
  - Reset mid-frame truncates the frame; the line returns high at once.
- FIFO push: wr_en=1 and full=0 at a rising edge writes wr_data.
  - Writes while full are dropped silently, even if a pop happens in the same cycle.
  - full and empty are registered and reflect the occupancy after the edge.
  - A push and pop in the same cycle leave the count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE, empty=0: pop the head word into the shift register, byte index = 0, go to START. sig_out=0 from the next edge.
  - START: hold sig_out=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: send bit k (k=0..BYTE_WIDTH-1) of the current byte for CLKS_PER_BIT cycles each, then STOP.
  - STOP: hold sig_out=1 for CLKS_PER_BIT cycles. If byte index < DATA_WIDTH/BYTE_WIDTH-1, increment the index and go straight to START with no idle gap. Otherwise assert word_done for 1 cycle and go to IDLE.
- IDLE always lasts at least 1 cycle between words.
- Bit timing uses a counter of width clog2(CLKS_PER_BIT). It reloads at every bit boundary, so there is no accumulated drift beyond truncation.
- Word duration: (DATA_WIDTH/BYTE_WIDTH)*(BYTE_WIDTH+2)*CLKS_PER_BIT cycles, plus 1 IDLE cycle.
- busy=1 in every state except IDLE.
- A write arriving while the FIFO is empty and the FSM is IDLE sets empty=0 at edge N. The pop happens at edge N+1, and sig_out falls at edge N+1.
- Pointer wrap: pointers are clog2(FIFO_DEPTH)+1 bits; full and empty are derived from MSB and index comparison.

Optional Feature:
UART_TX_PARITY_EN
- Defined: an even-parity bit (XOR of the byte's data bits) is sent after bit BYTE_WIDTH-1 and before the stop bit, for CLKS_PER_BIT cycles. State PARITY is added between DATA and STOP. The frame becomes 11 bits.
- Undefined: 8N1 frames, no PARITY state.

Test Plan (CLK_FREQ=1_000_000, BAUD_RATE=100_000 -> CLKS_PER_BIT=10, unless stated otherwise):
1. Reset asserted mid-frame on byte 2 -> sig_out=1 in the same timestep, empty=1, busy=0. After release, no further frames until a new write.
2. Single write 0xAABBCCDD -> bytes DD, CC, BB, AA appear on sig_out LSB first with 10-cycle bits. Total 400 cycles from the first falling edge. word_done pulses once, then busy=0.
3. Write 5 words back-to-back starting from empty -> the first is popped immediately, so all 5 are accepted and full=1 after the fifth. A sixth write while full is dropped. Exactly 5 words are transmitted in order, each followed by exactly 1 idle-high cycle.
4. Simultaneous wr_en with a pop when the FIFO holds 2 words -> occupancy stays 2. full and empty are unchanged.
5. Defaults (200 MHz, 115200) with word 0x0403FFEE -> each bit lasts 1736 cycles. A sampling receiver (the existing RX) recovers 0x0403FFEE.
6. UART_TX_PARITY_EN defined, word 0x00000007 -> byte 0x07 parity bit = 1, byte 0x00 parity bit = 0. Frame = 11 bits of 10 cycles; word = 440 cycles.

Source files
------------

// File: rtl/uart_word_tx.sv
// uart_word_tx: small word FIFO feeding a UART serialiser, LSB byte first.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module uart_word_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_FREQ   = 200_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic                  busy,
  output logic                  word_done,
  output logic                  sig_out
);

  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int NB  = DATA_WIDTH / BYTE_WIDTH;
  localparam int YW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int BW  = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] RELOAD    = CW'(CPB - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(BYTE_WIDTH - 1);
  localparam logic [YW-1:0] LAST_BYTE = YW'(NB - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t state, state_n;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wptr, rptr, wptr_n, rptr_n;
  logic                  push, pop;

  logic [CW-1:0]         cnt, cnt_n;
  logic [BW-1:0]         bit_idx, bit_n, nxt_bit;
  logic [YW-1:0]         byte_idx, byte_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic                  done_n, line_n;

  // full is the registered flag, so a write while full is dropped
  // even when the serialiser pops in the same cycle
  assign push   = wr_en & ~full;
  assign pop    = (state == IDLE) & ~empty;
  assign wptr_n = wptr + {{AW{1'b0}}, push};
  assign rptr_n = rptr + {{AW{1'b0}}, pop};
  assign busy   = (state != IDLE);

  always_ff @(posedge clock) begin
    if (push) mem[wptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      wptr  <= wptr_n;
      rptr  <= rptr_n;
      full  <= (wptr_n[AW] != rptr_n[AW]) &&
               (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
      empty <= (wptr_n == rptr_n);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      shreg     <= '0;
      word_done <= 1'b0;
      sig_out   <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      byte_idx  <= byte_n;
      shreg     <= shreg_n;
      word_done <= done_n;
      sig_out   <= line_n;
    end
  end

  assign nxt_bit = bit_idx + 1'b1;

  // line level is registered together with the state it belongs to
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    shreg_n = shreg;
    done_n  = 1'b0;
    line_n  = sig_out;
    unique case (state)
      IDLE: begin
        line_n = 1'b1;
        if (!empty) begin
          state_n = START;
          shreg_n = mem[rptr[AW-1:0]];
          byte_n  = '0;
          cnt_n   = RELOAD;
          line_n  = 1'b0;
        end
      end
      START: begin
        if (cnt == '0) begin
          state_n = DATA;
          cnt_n   = RELOAD;
          bit_n   = '0;
          line_n  = shreg[0];
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_n = RELOAD;
          if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            line_n  = ^shreg[BYTE_WIDTH-1:0];
`else
            state_n = STOP;
            line_n  = 1'b1;
`endif
          end else begin
            bit_n  = nxt_bit;
            line_n = shreg[nxt_bit];
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (cnt == '0) begin
          state_n = STOP;
          cnt_n   = RELOAD;
          line_n  = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt == '0) begin
          if (byte_idx == LAST_BYTE) begin
            state_n = IDLE;
            done_n  = 1'b1;
            line_n  = 1'b1;
          end else begin
            state_n = START;
            byte_n  = byte_idx + 1'b1;
            shreg_n = shreg >> BYTE_WIDTH;
            cnt_n   = RELOAD;
            line_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        line_n  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: random and directed stimulus against an occupancy/timing
// model and a sampling UART receiver; second instance runs default baud.
module tb_uart_word_tx;

  localparam int NB    = 4;
  localparam int DEPTH = 4;
  localparam int CPB   = 10;
  localparam int DCPB  = 200_000_000 / 115200;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int W = NB * FB * CPB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, wr_en;
  logic [31:0] wr_data;
  logic        full, empty, busy, word_done, sig_out;

  logic        rst_d, wr_en_d;
  logic [31:0] wr_data_d;
  logic        full_d, empty_d, busy_d, done_d, sig_d;

  uart_word_tx #(
    .DATA_WIDTH(32), .BYTE_WIDTH(8), .FIFO_DEPTH(DEPTH),
    .CLK_FREQ(1_000_000), .BAUD_RATE(100_000)
  ) dut (
    .clock(clk), .reset(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .busy(busy),
    .word_done(word_done), .sig_out(sig_out)
  );

  uart_word_tx dut_d (
    .clock(clk), .reset(rst_d), .wr_en(wr_en_d), .wr_data(wr_data_d),
    .full(full_d), .empty(empty_d), .busy(busy_d),
    .word_done(done_d), .sig_out(sig_d)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: occupancy count plus remaining transmit cycles
  int          m_cnt, m_busy_left, epoch;
  bit          m_done;
  bit          m_push, m_pop;
  logic [31:0] exp_q[$];

  initial epoch = 0;
  assign m_push = wr_en && (m_cnt < DEPTH);
  assign m_pop  = (m_busy_left == 0) && (m_cnt > 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt       <= 0;
      m_busy_left <= 0;
      m_done      <= 1'b0;
      exp_q.delete();
      epoch       <= epoch + 1;
    end else begin
      if (m_push) exp_q.push_back(wr_data);
      m_cnt       <= m_cnt + int'(m_push) - int'(m_pop);
      m_busy_left <= m_pop ? W : (m_busy_left > 0 ? m_busy_left - 1 : 0);
      m_done      <= (m_busy_left == 1);
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("busy", 32'(busy), 32'(m_busy_left > 0));
      chk("full", 32'(full), 32'(m_cnt == DEPTH));
      chk("empty", 32'(empty), 32'(m_cnt == 0));
      chk("word_done", 32'(word_done), 32'(m_done));
      if (m_busy_left == 0) chk("idle_line", 32'(sig_out), 1);
    end
  end

  function automatic logic line(input bit d);
    return d ? sig_d : sig_out;
  endfunction

  // called on the first negedge that sees the start bit low
  task automatic rx_frame(input bit d, input int cpb,
                          output logic [7:0] b, output bit ok);
    ok = 1'b1;
    b  = '0;
    repeat (cpb / 2) @(negedge clk);
    if (line(d) !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (cpb) @(negedge clk);
      b[i] = line(d);
    end
`ifdef UART_TX_PARITY_EN
    repeat (cpb) @(negedge clk);
    if (line(d) !== ^b) ok = 1'b0;
`endif
    repeat (cpb) @(negedge clk);
    if (line(d) !== 1'b1) ok = 1'b0;
  endtask

  initial begin : mon
    logic [7:0]  b;
    logic [31:0] wacc;
    bit          ok;
    int          e, we, bi;
    bi   = 0;
    we   = -1;
    wacc = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && sig_out === 1'b0) begin
        e = epoch;
        if (e != we) begin
          bi = 0;
          we = e;
        end
        rx_frame(1'b0, CPB, b, ok);
        if (epoch != e) begin
          bi = 0;
        end else begin
          chk("rx_frame", 32'(ok), 1);
          wacc[bi*8 +: 8] = b;
          bi++;
          if (bi == NB) begin
            bi = 0;
            if (exp_q.size() == 0) chk("rx_extra", 1, 0);
            else chk("rx_word", wacc, exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((m_cnt != 0 || m_busy_left != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 32'(n >= budget), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    rst_d     = 1'b0;
    wr_en_d   = 1'b0;
    wr_data_d = '0;
    fork
      begin : main_seq
        int n, low;
        repeat (3) @(negedge clk);
        chk("rst_line", 32'(sig_out), 1);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(word_done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        send(32'hAABBCCDD);
        wait_idle(W + 100, "single");
`ifdef UART_TX_PARITY_EN
        send(32'h00000007);
        wait_idle(W + 100, "parity");
`endif
        for (int i = 0; i < 6; i++) begin
          send($urandom);
          if (i == 4) chk("burst_full", 32'(full), 1);
        end
        chk("burst_drop_full", 32'(full), 1);
        wait_idle(6 * (W + 1) + 100, "burst");

        send(32'h01010101);
        send(32'h02020202);
        send(32'h03030303);
        n = 0;
        while (!(m_busy_left == 0 && m_cnt == 2) && n < 2 * W) begin
          @(negedge clk);
          n++;
        end
        chk("pp_reach_timeout", 32'(n >= 2 * W), 0);
        send(32'h04040404);
        chk("pp_full", 32'(full), 0);
        chk("pp_empty", 32'(empty), 0);
        chk("pp_busy", 32'(busy), 1);
        wait_idle(4 * (W + 1) + 100, "pushpop");

        for (int c = 0; c < 3000; c++) begin
          wr_en   = ($urandom_range(0, 99) < 4);
          wr_data = $urandom;
          @(negedge clk);
        end
        wr_en = 1'b0;
        wait_idle((DEPTH + 1) * (W + 1) + 100, "random");

        send(32'h11223344);
        repeat (1 + 2 * FB * CPB + 35) @(negedge clk);
        chk("mid_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_line", 32'(sig_out), 1);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_full", 32'(full), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        low = 0;
        for (int c = 0; c < 100; c++) begin
          @(negedge clk);
          if (sig_out !== 1'b1) low++;
        end
        chk("post_rst_quiet", 32'(low), 0);
        send(32'hCAFEF00D);
        wait_idle(W + 100, "recover");
        chk("drain", 32'(exp_q.size()), 0);
      end
      begin : dflt_seq
        logic [7:0] b;
        bit         ok;
        int         n, t0;
        repeat (2) @(negedge clk);
        rst_d = 1'b1;
        @(negedge clk);
        wr_en_d   = 1'b1;
        wr_data_d = 32'h0403FFEE;
        @(negedge clk);
        wr_en_d   = 1'b0;
        n = 0;
        while (sig_d !== 1'b0 && n < 100) begin
          @(negedge clk);
          n++;
        end
        chk("d_start_timeout", 32'(n >= 100), 0);
        t0 = cyc;
        rx_frame(1'b1, DCPB, b, ok);
        chk("d_frame0", 32'(ok), 1);
        chk("d_byte0", 32'(b), 32'h0EE);
        n = 0;
        while (sig_d !== 1'b0 && n < 2 * DCPB) begin
          @(negedge clk);
          n++;
        end
        chk("d_frame_period", 32'(cyc - t0), 32'(FB * DCPB));
        rx_frame(1'b1, DCPB, b, ok);
        chk("d_frame1", 32'(ok), 1);
        chk("d_byte1", 32'(b), 32'h0FF);
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
